// File: rtl/cache_pmem_arbiter_pkg.sv
// Shared types and sizing for the I/D cache physical-memory arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (see cache_pmem_arbiter.sv).
package cache_pmem_arbiter_pkg;

    localparam int ARB_BEATS  = 4;
    localparam int ARB_BEAT_W = 64;

    // FSM encoding kept as plain constants so older code can compare raw bits
    typedef logic [2:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 3'd0;
    localparam arb_state_t ST_I_RD = 3'd1;
    localparam arb_state_t ST_D_RD = 3'd2;
    localparam arb_state_t ST_D_WR = 3'd3;
    localparam arb_state_t ST_DONE = 3'd4;

    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} arb_grant_t;

    // Clear the byte-within-line offset bits of an address
    function automatic logic [31:0] line_align(input logic [31:0] a, input int off_w);
        return a & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_pmem_arbiter_if.sv
// Cache-side and pmem-side bus bundle for cache_pmem_arbiter.
// slave = arbiter view, master = caches + memory view.
interface cache_pmem_arbiter_if
    import cache_pmem_arbiter_pkg::*;
#(
    parameter int BEATS  = ARB_BEATS,
    parameter int BEAT_W = ARB_BEAT_W
);
    localparam int LINE_W = BEATS * BEAT_W;

    logic              i_read;
    logic [31:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_pmem_arbiter_line_beat_buffer.sv
// One cache line of storage shared by read fills and writebacks:
// beat-indexed fill port, whole-line load port, beat-indexed read mux.
module cache_pmem_arbiter_line_beat_buffer #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       beat_we,
    input  logic [$clog2(BEATS)-1:0]   beat_idx,
    input  logic [BEAT_W-1:0]          beat_wdata,
    input  logic                       line_ld,
    input  logic [BEATS*BEAT_W-1:0]    line_wdata,
    output logic [BEATS*BEAT_W-1:0]    line_q,
    output logic [BEAT_W-1:0]          beat_q
);

    logic [BEATS-1:0][BEAT_W-1:0] beats;

    // Whole-line load has priority; otherwise fill the addressed beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats <= '0;
        end else if (line_ld) begin
            beats <= line_wdata;
        end else if (beat_we) begin
            beats[beat_idx] <= beat_wdata;
        end
    end

    assign line_q = beats;
    assign beat_q = beats[beat_idx];

endmodule

// File: rtl/cache_pmem_arbiter.sv
// Arbitrates the single burst pmem port between I-cache and D-cache.
// Each grant runs a BEATS-beat burst, then one DONE cycle with resp.
// Build macro ARB_ROUND_ROBIN_EN: when defined, the requester not served
// last gets priority; otherwise D always beats I. D write beats D read.
module cache_pmem_arbiter
    import cache_pmem_arbiter_pkg::*;
#(
    parameter int BEATS  = ARB_BEATS,
    parameter int BEAT_W = ARB_BEAT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_pmem_arbiter_if.slave  bus
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    arb_state_t        state, nxt_st;
    arb_grant_t        gnt, nxt_gnt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr, req_addr;
    logic              i_first, grant_fire, line_ld, beat_we;
    logic [LINE_W-1:0] line_q;
    logic [BEAT_W-1:0] beat_q;

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t last_gnt;

    // Remember who was served last so the other side goes first next time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            last_gnt <= GNT_I;
        else if (grant_fire) last_gnt <= nxt_gnt;
    end

    assign i_first = (last_gnt == GNT_D);
`else
    assign i_first = 1'b0;
`endif

    // Pick the next grant from live requests; only acted on in IDLE
    always_comb begin
        nxt_st   = ST_IDLE;
        nxt_gnt  = GNT_NONE;
        req_addr = bus.d_address;
        if (bus.i_read && (i_first || !(bus.d_read || bus.d_write))) begin
            nxt_st   = ST_I_RD;
            nxt_gnt  = GNT_I;
            req_addr = bus.i_address;
        end else if (bus.d_write) begin
            nxt_st  = ST_D_WR;
            nxt_gnt = GNT_D;
        end else if (bus.d_read) begin
            nxt_st  = ST_D_RD;
            nxt_gnt = GNT_D;
        end
    end

    assign grant_fire = (state == ST_IDLE) && (nxt_gnt != GNT_NONE);
    assign line_ld    = grant_fire && (nxt_st == ST_D_WR);
    assign beat_we    = bus.pmem_read && bus.pmem_resp;

    // FSM, beat counter, latched grant and burst address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= GNT_NONE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        state <= nxt_st;
                        gnt   <= nxt_gnt;
                        addr  <= line_align(req_addr, OFF_W);
                    end
                end
                ST_I_RD, ST_D_RD, ST_D_WR: begin
                    if (bus.pmem_resp) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    cache_pmem_arbiter_line_beat_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .beat_we    (beat_we),
        .beat_idx   (cnt),
        .beat_wdata (bus.pmem_rdata),
        .line_ld    (line_ld),
        .line_wdata (bus.d_wdata),
        .line_q     (line_q),
        .beat_q     (beat_q)
    );

    assign bus.pmem_read    = (state == ST_I_RD) || (state == ST_D_RD);
    assign bus.pmem_write   = (state == ST_D_WR);
    assign bus.pmem_address = addr;
    assign bus.pmem_wdata   = (state == ST_D_WR) ? beat_q : '0;
    assign bus.i_resp       = (state == ST_DONE) && (gnt == GNT_I);
    assign bus.d_resp       = (state == ST_DONE) && (gnt == GNT_D);
    assign bus.i_rdata      = line_q;
    assign bus.d_rdata      = line_q;

endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
Shares the single 64-bit burst physical-memory port between the instruction cache and the data cache. Each cache issues whole-line requests; the arbiter selects one, runs a fixed 4-beat burst on pmem, and assembles or splits the line. It sits between the two caches and the `mp4` top-level pmem ports.

Parameters:
- BEATS, 4, number of pmem beats per cache line
- BEAT_W, 64, pmem data width in bits; line width LINE_W = BEATS*BEAT_W (256)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  32  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_address  in  32  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  burst read to physical memory
- pmem_write  out  1  burst write to physical memory
- pmem_address  out  32  line-aligned burst address
- pmem_wdata  out  BEAT_W  current write beat
- pmem_rdata  in  BEAT_W  current read beat
- pmem_resp  in  1  beat accepted or valid

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- Reset (rst low, any cycle, including mid-burst) forces the following immediately: state IDLE, beat counter 0, grant none.
  - All outputs go low/zero: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata, i_rdata, d_rdata.
- IDLE: sample requests at the clock edge.
  - Default priority: D over I.
  - d_write -> D_WR; else d_read -> D_RD; else i_read -> I_RD.
  - If d_read and d_write are both high, the write wins.
- Grant is latched. The request address is captured at grant with bits [4:0] zeroed, and pmem_address holds it for the whole burst.
- D_WR: d_wdata is captured at grant. pmem_write stays high.
  - pmem_wdata = captured line[cnt*BEAT_W +: BEAT_W].
  - cnt increments on each pmem_resp.
- D_RD / I_RD: pmem_read stays high.
  - On pmem_resp, pmem_rdata is written into line buffer slice cnt, then cnt increments.
- On the pmem_resp with cnt==BEATS-1:
  - pmem_read/pmem_write drop in the next cycle; cnt wraps to 0.
  - State goes to DONE.
- DONE lasts exactly one cycle:
  - The granted requester's resp is high.
  - i_rdata/d_rdata hold the assembled line. The buffer stays stable until the next grant.
  - Then go to IDLE.
- The requester deasserts its request in the cycle after resp. The arbiter samples requests only in IDLE, so a request still high during DONE is not re-granted early.
- Latency, with 0-wait pmem:
  - Request high at edge T.
  - pmem_read/write asserted from T+1.
  - Four beats complete at T+4.
  - resp asserted at T+5.
  - Minimum 6 cycles from request to IDLE.
- pmem_resp outside I_RD/D_RD/D_WR is ignored.
- Requests arriving mid-burst wait and are evaluated in the next IDLE. No request is dropped.
- At most one of pmem_read/pmem_write is high in any cycle.
- At most one of i_resp/d_resp is high in any cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
  - Defined: a last-granted flop (reset = I) gives priority to the requester not served last. Within D, write-over-read still holds.
  - Undefined: fixed D-over-I priority. I may starve under continuous D traffic, which is acceptable.

Decomposition:
- Shared package rv32i_types (or the existing cache package) gets:
  - arb_state_t enum {IDLE, I_RD, D_RD, D_WR, DONE}
  - arb_grant_t enum {GNT_NONE, GNT_I, GNT_D}
  - localparams for BEATS/BEAT_W
- One natural sub-module: line_beat_buffer, a LINE_W register holding:
  - beat-indexed write port (read fill)
  - full-line load (writeback capture)
  - beat-indexed read mux for pmem_wdata
- Top arbiter holds the FSM, counter and grant logic.

Test Plan:
- Reset mid-burst: assert rst low during D_RD beat 2 -> all outputs 0 immediately; after release, state IDLE, next i_read starts a fresh burst at beat 0.
- I-read alone, i_address=0x0000_1234, pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_address=0x0000_1220, i_rdata={0x44..,0x33..,0x22..,0x11..}, i_resp one cycle at T+5.
- D-write, d_wdata beats A,B,C,D, pmem_resp every other cycle -> pmem_wdata shows A,B,C,D in order, each held until its resp; d_resp once; pmem_write never high with pmem_read.
- Simultaneous i_read and d_read at same edge -> D served first; I then served with no gap beyond IDLE. With ARB_ROUND_ROBIN_EN after a prior D grant -> I served first.
- d_read and d_write both high -> D_WR burst only, single d_resp.
